// File: rtl/pr_block_responder.sv
// Device-side responder for the PR handshake: checks MAGIC, length, payload checksum; reports done/error.
// Optional build macro PR_ERROR_INJECT_EN adds an inject_error input that forces a CHECK-word rejection.
module pr_block_responder #(
  parameter logic [15:0] Magic      = 16'hA5C3,
  parameter int unsigned MaxWords   = 1024,
  parameter int unsigned RdyLatency = 4,
  parameter int unsigned Timeout    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        corectl,
  input  logic        prrequest,
  input  logic        data_valid,
  input  logic [15:0] data,
`ifdef PR_ERROR_INJECT_EN
  input  logic        inject_error,
`endif
  output logic        ready,
  output logic        done,
  output logic        error,
  output logic [15:0] payload_count
);

  localparam int unsigned DlyW  = $clog2(RdyLatency + 1);
  localparam int unsigned IdleW = $clog2(Timeout + 1);

  localparam logic [15:0]      MaxLen   = 16'(MaxWords);
  localparam logic [DlyW-1:0]  DlyLast  = DlyW'(RdyLatency - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(Timeout - 1);

  typedef enum logic [2:0] {
    StIdle, StWaitRdy, StHeader, StLength, StPayload, StCheck, StDone, StError
  } state_e;

  state_e           state_q, state_d;
  logic [DlyW-1:0]  dly_q, dly_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      sum_q, sum_d;
  logic [15:0]      count_q, count_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic in_xfer, accept, abort, timeout, check_ok, len_ok;

  assign in_xfer = state_q inside {StHeader, StLength, StPayload, StCheck};
  assign accept  = ready_q && data_valid;
  assign abort   = !prrequest;
  assign timeout = in_xfer && !accept && (idle_q == IdleLast);
  assign len_ok  = (data != 16'd0) && (data <= MaxLen);

`ifdef PR_ERROR_INJECT_EN
  assign check_ok = (data == sum_q) && !inject_error;
`else
  assign check_ok = (data == sum_q);
`endif

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    len_d   = len_q;
    sum_d   = sum_q;
    count_d = count_q;
    // Idle timer only runs while ready is up; any accepted word restarts it.
    if (!in_xfer || accept) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (prrequest && corectl) begin
          state_d = StWaitRdy;
          dly_d   = '0;
          len_d   = '0;
          sum_d   = '0;
          count_d = '0;
        end
      end
      StWaitRdy: begin
        if (abort) begin
          state_d = StError;
        end else if (dly_q == DlyLast) begin
          state_d = StHeader;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      StHeader: begin
        if (abort || timeout) begin
          state_d = StError;
        end else if (accept) begin
          state_d = (data == Magic) ? StLength : StError;
        end
      end
      StLength: begin
        if (abort || timeout) begin
          state_d = StError;
        end else if (accept) begin
          if (len_ok) begin
            len_d   = data;
            state_d = StPayload;
          end else begin
            state_d = StError;
          end
        end
      end
      StPayload: begin
        if (abort || timeout) begin
          state_d = StError;
        end else if (accept) begin
          sum_d = sum_q + data;
          if (count_q != MaxLen) begin
            count_d = count_q + 16'd1;
          end
          if (count_q + 16'd1 == len_q) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (abort || timeout) begin
          state_d = StError;
        end else if (accept) begin
          state_d = check_ok ? StDone : StError;
        end
      end
      StDone, StError: begin
        if (abort) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flags are registered copies of the next state, so outputs never see inputs combinationally.
    ready_d = state_d inside {StHeader, StLength, StPayload, StCheck};
    done_d  = (state_d == StDone);
    error_d = (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dly_q   <= '0;
      idle_q  <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      idle_q  <= idle_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign ready         = ready_q;
  assign done          = done_q;
  assign error         = error_q;
  assign payload_count = count_q;

endmodule
